hc4051_scan_ctrl: RTL and testbench
===================================

# hc4051_scan_ctrl

Sequencer for the HC4051 8:1 analog monitor mux: steps the select lines through a masked set of channels, holds each channel for a programmable settle time, requests one ADC conversion per channel, and returns each result tagged with its channel number. It sits between the board control registers (START/STOP/mask/mode) and the HC4051 plus its downstream ADC. It owns S[2:0] and ENABLE_ exclusively.

## Interface
- SETTLE_CYC, 16: cycles the mux is enabled on a channel before CONV rises; legal range 1..255.
- TIMEOUT_CYC, 1024: CONV watchdog length in cycles (used only with the timeout feature).
- ADC_W, 12: ADC result width.
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high; one clock; one clock domain only.
- START  in  1  begin a scan; sampled only in IDLE.
- STOP  in  1  abort the current scan.
- CONT  in  1  1 = rescan forever, 0 = single pass; sampled at each wrap.
- CHAN_MASK  in  8  bit i enables channel i; captured at START and at each wrap.
- S  out  3  HC4051 address.
- ENABLE_  out  1  HC4051 enable, active low.
- CONV  out  1  ADC conversion request (level).
- CONV_DONE  in  1  ADC done strobe; ADC_DATA valid in the same cycle.
- ADC_DATA  in  ADC_W  conversion result.
- RESULT_VALID  out  1  one-cycle result strobe.
- RESULT_CHAN  out  3  channel of the result.
- RESULT_DATA  out  ADC_W  captured sample.
- BUSY  out  1  high in every state except IDLE.
- ERR_TIMEOUT  out  1  sticky conversion-timeout flag.

## Operation
- States: IDLE, SETTLE, CONVERT, NEXT.
- IDLE: ENABLE_=1, CONV=0. START=1 with nonzero CHAN_MASK captures the mask, loads S with the lowest enabled channel, and enters SETTLE. START with mask 0 is ignored.
- SETTLE: ENABLE_=0. The counter runs SETTLE_CYC cycles, then the block enters CONVERT.
- CONVERT: ENABLE_=0, CONV=1 until CONV_DONE is sampled high. In that cycle ADC_DATA is captured and the block enters NEXT.
- NEXT, one cycle: ENABLE_=1 (break-before-make), CONV=0, RESULT_VALID=1 with RESULT_CHAN/RESULT_DATA.
  - Then S advances to the next higher enabled channel and the block enters SETTLE.
  - After the highest enabled channel it wraps. With CONT=1 it recaptures CHAN_MASK and continues from the lowest enabled channel; a recaptured mask of 0 goes to IDLE.
  - With CONT=0 it goes to IDLE.
- STOP=1 in any non-IDLE state: IDLE next cycle, ENABLE_=1, CONV=0, no RESULT_VALID. STOP has priority over CONV_DONE in the same cycle.
- START while BUSY is ignored. CHAN_MASK changes mid-pass take effect only at the wrap.
- RESULT_CHAN/RESULT_DATA hold their last values between strobes.
- Reset values: state IDLE, S=0, ENABLE_=1, CONV=0, RESULT_VALID=0, RESULT_CHAN=0, RESULT_DATA=0, BUSY=0, ERR_TIMEOUT=0. RESET mid-scan behaves exactly as these values, with no result strobe.

## Timing
- START sampled at cycle N: at N+1, S=first channel, ENABLE_=0, BUSY=1.
- CONV rises at N+1+SETTLE_CYC.
- CONV_DONE sampled at cycle M: at M+1, CONV=0, ENABLE_=1, RESULT_VALID=1.
- At M+2, S=next channel and ENABLE_=0.
- Per-channel period: SETTLE_CYC + (CONVERT cycles) + 1.
- CONV_DONE is ignored outside CONVERT.
- S changes only in cycles where ENABLE_=1.

## Configuration
- HC4051_SCAN_TIMEOUT_EN defined: a counter runs in CONVERT.
  - On reaching TIMEOUT_CYC cycles without CONV_DONE, it sets ERR_TIMEOUT and enters NEXT with RESULT_VALID suppressed; the scan continues.
  - ERR_TIMEOUT clears on RESET or on an accepted START.
- Not defined: CONVERT waits indefinitely, and ERR_TIMEOUT is tied to 0.

## Test plan
- Reset with SETTLE_CYC=4, mask 8'hFF, CONT=0, ADC returning 12'h100+chan two cycles after CONV: 8 RESULT_VALID strobes, chan 0..7, data 12'h100..12'h107, then IDLE with BUSY=0 and ENABLE_=1.
- Mask 8'b1000_0101, CONT=1: result channels 0,2,7,0,2,7…. Change mask to 8'h10 mid-pass: the current pass finishes, then only channel 4 repeats.
- STOP asserted on the same cycle as CONV_DONE on channel 3: no strobe, next cycle IDLE, ENABLE_=1, CONV=0.
- START with mask 0: stays IDLE, BUSY=0. START while BUSY: no effect on the sequence.
- RESET pulsed in SETTLE of channel 5: next cycle all outputs at their reset values. A fresh START restarts at the lowest enabled channel.
- With HC4051_SCAN_TIMEOUT_EN and TIMEOUT_CYC=8, CONV_DONE withheld on channel 2: after 8 CONVERT cycles ERR_TIMEOUT=1, no strobe for channel 2, and channel 3 proceeds. ERR_TIMEOUT clears on the next START.

Source files
------------

// File: rtl/hc4051_scan_ctrl.sv
// hc4051_scan_ctrl: sequences an HC4051 8:1 mux over masked channels, settles, triggers one ADC conversion each, returns tagged results.
// Ports: clk_i/rst_i (sync active-high); start_i, stop_i, cont_i, chan_mask_i[7:0] from control regs;
//        s_o[2:0], enable_n_o to the mux; conv_o, conv_done_i, adc_data_i[ADC_W-1:0] with the ADC;
//        result_valid_o, result_chan_o[2:0], result_data_o[ADC_W-1:0], busy_o, err_timeout_o status.
// Define HC4051_SCAN_TIMEOUT_EN to enable the CONVERT watchdog; otherwise err_timeout_o stays 0.
module hc4051_scan_ctrl #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int ADC_W       = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             cont_i,
  input  logic [7:0]       chan_mask_i,
  output logic [2:0]       s_o,
  output logic             enable_n_o,
  output logic             conv_o,
  input  logic             conv_done_i,
  input  logic [ADC_W-1:0] adc_data_i,
  output logic             result_valid_o,
  output logic [2:0]       result_chan_o,
  output logic [ADC_W-1:0] result_data_o,
  output logic             busy_o,
  output logic             err_timeout_o
);
  typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, NEXT} state_t;
  state_t           state_q, state_d;
  logic [7:0]       mask_q, mask_d, cnt_q, cnt_d;
  logic [2:0]       s_q, s_d, chan_q, chan_d;
  logic [ADC_W-1:0] data_q, data_d;
  logic             more_q, more_d, valid_q, valid_d, err_q, err_d, tmo_hit;
  logic [3:0]       nxt, low_new;
  // {found, index} of the lowest set bit of m at or above position from
  function automatic logic [3:0] first_from(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 7; i >= 0; i--)
      if (m[i] && i >= int'(from)) r = {1'b1, 3'(i)};
    return r;
  endfunction
`ifdef HC4051_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign tmo_hit = state_q == CONVERT && tmo_q == TW'(TIMEOUT_CYC - 1);
  assign tmo_d   = state_q == CONVERT ? tmo_q + 1'b1 : '0;
  always_ff @(posedge clk_i)
    tmo_q <= rst_i ? '0 : tmo_d;
`else
  assign tmo_hit = 1'b0;
`endif
  assign nxt     = first_from(mask_q, {1'b0, s_q} + 4'd1);
  assign low_new = first_from(chan_mask_i, 4'd0);
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    chan_d  = chan_q;
    data_d  = data_q;
    more_d  = more_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (stop_i && state_q != IDLE) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start_i && |chan_mask_i) begin
          mask_d  = chan_mask_i;
          s_d     = low_new[2:0];
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = SETTLE;
        end
        SETTLE: begin
          cnt_d   = cnt_q + 8'd1;
          state_d = cnt_q == 8'(SETTLE_CYC - 1) ? CONVERT : SETTLE;
        end
        CONVERT: if (conv_done_i || tmo_hit) begin
          valid_d = conv_done_i;
          chan_d  = conv_done_i ? s_q : chan_q;
          data_d  = conv_done_i ? adc_data_i : data_q;
          err_d   = err_q | ~conv_done_i;
          state_d = NEXT;
          // S moves while the mux is disabled in NEXT; wrap recaptures the mask if continuous
          if (nxt[3]) begin
            s_d    = nxt[2:0];
            more_d = 1'b1;
          end else if (cont_i && |chan_mask_i) begin
            mask_d = chan_mask_i;
            s_d    = low_new[2:0];
            more_d = 1'b1;
          end else
            more_d = 1'b0;
        end
        NEXT: begin
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = more_q ? SETTLE : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      chan_q  <= '0;
      data_q  <= '0;
      more_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      chan_q  <= chan_d;
      data_q  <= data_d;
      more_q  <= more_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  assign s_o            = s_q;
  assign enable_n_o     = !(state_q == SETTLE || state_q == CONVERT);
  assign conv_o         = state_q == CONVERT;
  assign result_valid_o = state_q == NEXT && valid_q;
  assign result_chan_o  = chan_q;
  assign result_data_o  = data_q;
  assign busy_o         = state_q != IDLE;
  assign err_timeout_o  = err_q;
endmodule

// File: tb/tb_hc4051_scan_ctrl.sv
// tb_hc4051_scan_ctrl: randomized self-checking bench for hc4051_scan_ctrl against a channel-list reference model.
module tb_hc4051_scan_ctrl;
  localparam int SC = 4, TO = 8, W = 12;
  logic clk = 1'b0, rst_i, start_i, stop_i, cont_i, conv_done_i;
  logic [7:0] chan_mask_i;
  logic [W-1:0] adc_data_i, result_data_o;
  logic [2:0] s_o, result_chan_o;
  logic enable_n_o, conv_o, result_valid_o, busy_o, err_timeout_o;
  hc4051_scan_ctrl #(.SETTLE_CYC(SC), .TIMEOUT_CYC(TO), .ADC_W(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i), .cont_i(cont_i),
    .chan_mask_i(chan_mask_i), .s_o(s_o), .enable_n_o(enable_n_o), .conv_o(conv_o),
    .conv_done_i(conv_done_i), .adc_data_i(adc_data_i), .result_valid_o(result_valid_o),
    .result_chan_o(result_chan_o), .result_data_o(result_data_o), .busy_o(busy_o),
    .err_timeout_o(err_timeout_o));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  int adc_delay = 2, hold_chan = -1, stop_chan = -1;
  bit stop_req = 0, stop_fired = 0, rnd_delay = 0;
  logic [W-1:0] dbase = 12'h100;
  initial begin
    int ccnt, dly;
    bit fire;
    ccnt = 0;
    dly = 2;
    conv_done_i = 1'b0;
    adc_data_i = '0;
    stop_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      fire = 0;
      if (conv_o && int'(s_o) != hold_chan) begin
        if (ccnt == dly) begin
          conv_done_i = 1'b1;
          adc_data_i = dbase + W'(s_o);
          fire = int'(s_o) == stop_chan;
        end else conv_done_i = 1'b0;
        ccnt++;
      end else begin
        conv_done_i = 1'b0;
        ccnt = 0;
        dly = rnd_delay ? int'($urandom_range(3, 0)) : adc_delay;
      end
      stop_i = stop_req | fire;
      if (fire) stop_fired = 1;
    end
  end
  int gch[$], gdt[$], gcy[$], exp_q[$];
  initial forever begin
    @(negedge clk);
    if (result_valid_o) begin
      gch.push_back(int'(result_chan_o));
      gdt.push_back(int'(result_data_o));
      gcy.push_back(cyc);
      chk("strobe_enable_n", enable_n_o, 1);
      chk("strobe_conv", conv_o, 0);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    gch.delete(); gdt.delete(); gcy.delete(); exp_q.delete();
  endtask
  task automatic add_pass(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) exp_q.push_back(i);
  endtask
  task automatic start(input logic [7:0] m, input logic c);
    chan_mask_i = m; cont_i = c; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask
  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy_o && n < max) begin tick(); n++; end
    chk(tag, busy_o, 0);
  endtask
  task automatic wait_results(input string tag, input int k, input int max);
    int n = 0;
    while (gch.size() < k && n < max) begin tick(); n++; end
    chk(tag, gch.size() >= k, 1);
  endtask
  task automatic check_results(input string tag);
    logic [W-1:0] ed;
    chk({tag, "_count"}, gch.size(), exp_q.size());
    for (int i = 0; i < gch.size() && i < exp_q.size(); i++) begin
      ed = dbase + W'(exp_q[i]);
      chk({tag, "_chan"}, gch[i], exp_q[i]);
      chk({tag, "_data"}, gdt[i], int'(ed));
    end
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_s"}, s_o, 0);
    chk({tag, "_enable_n"}, enable_n_o, 1);
    chk({tag, "_conv"}, conv_o, 0);
    chk({tag, "_rvalid"}, result_valid_o, 0);
    chk({tag, "_rchan"}, result_chan_o, 0);
    chk({tag, "_rdata"}, result_data_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_err"}, err_timeout_o, 0);
  endtask
  initial begin
    int n, k, pc;
    logic [7:0] m;
    logic c;
    rst_i = 1'b1; start_i = 1'b0; cont_i = 1'b0; chan_mask_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    check_reset_vals("reset");
    // full mask single pass with fixed ADC latency
    clr();
    start(8'hFF, 1'b0);
    chk("start_s", s_o, 0);
    chk("start_enable_n", enable_n_o, 0);
    chk("start_busy", busy_o, 1);
    n = 0;
    while (!conv_o && n < 50) begin tick(); n++; end
    chk("settle_len", n, SC);
    wait_idle("full_idle", 200);
    add_pass(8'hFF);
    check_results("full");
    if (gcy.size() >= 2) chk("period", gcy[1] - gcy[0], SC + adc_delay + 2);
    chk("full_end_enable_n", enable_n_o, 1);
    // continuous scan with mid-pass mask change
    clr();
    start(8'b1000_0101, 1'b1);
    wait_results("cont_4", 4, 200);
    chan_mask_i = 8'h10;
    wait_results("cont_9", 9, 300);
    stop_req = 1; tick(); tick(); stop_req = 0;
    wait_idle("cont_idle", 20);
    exp_q = '{0, 2, 7, 0, 2, 7, 4, 4, 4};
    check_results("cont");
    // STOP coincident with CONV_DONE on channel 3
    clr();
    stop_chan = 3;
    start(8'h0F, 1'b0);
    n = 0;
    while (!stop_fired && n < 200) begin @(negedge clk); n++; end
    chk("stopdone_fired", stop_fired, 1);
    @(negedge clk);
    chk("stopdone_busy", busy_o, 0);
    chk("stopdone_enable_n", enable_n_o, 1);
    chk("stopdone_conv", conv_o, 0);
    chk("stopdone_rvalid", result_valid_o, 0);
    stop_chan = -1; stop_fired = 0;
    tick(); tick();
    add_pass(8'h07);
    check_results("stopdone");
    chk("stopdone_hold_chan", result_chan_o, 2);
    // START with empty mask, START while busy
    start(8'h00, 1'b0);
    tick(); tick();
    chk("mask0_busy", busy_o, 0);
    chk("mask0_enable_n", enable_n_o, 1);
    clr();
    start(8'h06, 1'b0);
    tick(); tick(); tick();
    start(8'hF0, 1'b0);
    wait_idle("busystart_idle", 100);
    add_pass(8'h06);
    check_results("busystart");
    // RESET during SETTLE of channel 5
    clr();
    start(8'hFF, 1'b0);
    n = 0;
    while (!(s_o == 3'd5 && !enable_n_o && !conv_o) && n < 200) begin tick(); n++; end
    chk("rst5_reached", s_o, 5);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    check_reset_vals("midreset");
    tick(); tick(); tick();
    chk("midreset_strobes", gch.size(), 5);
    clr();
    start(8'h24, 1'b0);
    chk("restart_s", s_o, 2);
    wait_idle("restart_idle", 100);
    add_pass(8'h24);
    check_results("restart");
    // randomized masks, modes, latencies and data
    rnd_delay = 1;
    for (int it = 0; it < 10; it++) begin
      clr();
      m = 8'($urandom_range(255, 1));
      c = 1'($urandom_range(1, 0));
      dbase = W'($urandom);
      pc = $countones(m);
      start(m, c);
      if (c) begin
        k = int'($urandom_range(3 * pc, 1));
        wait_results("rnd_wait", k, 50 * k);
        stop_req = 1; tick(); stop_req = 0;
        wait_idle("rnd_stop_idle", 20);
        for (int i = 0; i < k; i++) begin
          if (exp_q.size() <= i) add_pass(m);
        end
        while (exp_q.size() > k) void'(exp_q.pop_back());
      end else begin
        wait_idle("rnd_idle", 400);
        add_pass(m);
      end
      check_results("rnd");
    end
    rnd_delay = 0;
`ifdef HC4051_SCAN_TIMEOUT_EN
    clr();
    dbase = 12'h100;
    hold_chan = 2;
    start(8'h0C, 1'b0);
    n = 0;
    while (!conv_o && n < 50) begin tick(); n++; end
    n = 0;
    while (conv_o && n < 50) begin tick(); n++; end
    chk("tmo_len", n, TO);
    chk("tmo_err", err_timeout_o, 1);
    wait_idle("tmo_idle", 100);
    add_pass(8'h08);
    check_results("tmo");
    chk("tmo_err_sticky", err_timeout_o, 1);
    hold_chan = -1;
    start(8'h01, 1'b0);
    chk("tmo_err_clear", err_timeout_o, 0);
    wait_idle("tmo_clear_idle", 100);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
